// File: rtl/dacx_multich_driver.sv
// dacx_multich_driver: SPI driver for DACx0004-family DACs with config replay and masked multi-channel frames
// Ports:
//   clk100mhz, rst        system clock, synchronous active-high reset
//   i_enable              starts the configuration replay from IDLE (sampled only in IDLE)
//   i_cfg_words           N_CFG 32-bit configuration words, word k at [32k+31:32k], sent in ascending k
//   i_data, i_ch_mask     frame samples (channel c at [c*DATA_W +: DATA_W]) and per-channel write enables
//   i_frame_valid/o_frame_ready  frame handshake
//   o_cfg_done            sticky flag once the configuration list has been sent
//   o_busy                high outside IDLE and WAIT_FRAME
//   o_sdo, o_sck, o_cs, o_nldac  DAC pins (SCK idles high, CS and LDAC active-low)
// Optional feature macro: DACX_LDAC_SYNC_EN -- channel writes only load the input buffers and a
// single 8-cycle LDAC pulse after the frame updates all channels together.
module dacx_multich_driver #(
    parameter int N_CH    = 4,
    parameter int DATA_W  = 16,
    parameter int SCK_DIV = 2,
    parameter int N_CFG   = 6,
    parameter int CS_GAP  = 32
) (
    input  logic                   clk100mhz,
    input  logic                   rst,
    input  logic                   i_enable,
    input  logic [32*N_CFG-1:0]    i_cfg_words,
    input  logic [N_CH*DATA_W-1:0] i_data,
    input  logic [N_CH-1:0]        i_ch_mask,
    input  logic                   i_frame_valid,
    output logic                   o_frame_ready,
    output logic                   o_cfg_done,
    output logic                   o_busy,
    output logic                   o_sdo,
    output logic                   o_sck,
    output logic                   o_cs,
    output logic                   o_nldac
);
`ifdef DACX_LDAC_SYNC_EN
    localparam logic [3:0] CMD     = 4'b0000;
    localparam bit         LDAC_EN = 1'b1;
`else
    localparam logic [3:0] CMD     = 4'b0011;
    localparam bit         LDAC_EN = 1'b0;
`endif
    localparam int LDAC_LEN = 8;
    // Two lead-in SCK-high halves followed by a low and a high half per bit.
    localparam int HALVES   = 66;
    localparam int T_A      = CS_GAP > SCK_DIV ? CS_GAP : SCK_DIV;
    localparam int T_MAX    = T_A > LDAC_LEN ? T_A : LDAC_LEN;
    localparam int TW       = $clog2(T_MAX + 1);

    typedef enum logic [2:0] {
        IDLE, CFG_SEND, CFG_GAP, WAIT_FRAME, CH_SEND, CH_GAP, LDAC_PULSE
    } state_t;

    state_t                  state, state_nx;
    logic [TW-1:0]           tick;
    logic [6:0]              half;
    logic [2:0]              k;
    logic [31:0]             sh;
    logic                    pend;
    logic [N_CH-1:0]         rem;
    logic [N_CH*DATA_W-1:0]  data_q;
    logic                    cfg_done;

    logic                    sending, send_end, gap_end, ldac_end, half_end;
    logic [3:0]              nxt_ch;
    logic [DATA_W-1:0]       sample;
    logic [15:0]             just;
    logic [31:0]             ch_word, cfg_word;
    logic [2:0]              k_nx;
    logic [N_CH-1:0]         ch_bit;

    assign sending  = state == CFG_SEND || state == CH_SEND;
    assign half_end = tick == TW'(SCK_DIV - 1);
    assign send_end = sending && half == 7'(HALVES - 1) && half_end;
    assign gap_end  = tick == TW'(CS_GAP - 1);
    assign ldac_end = tick == TW'(LDAC_LEN - 1);

    // Lowest channel still pending in the captured mask.
    always_comb begin
        nxt_ch = '0;
        for (int i = N_CH - 1; i >= 0; i--)
            if (rem[i]) nxt_ch = 4'(i);
    end

    always_comb begin
        sample   = data_q[int'(nxt_ch) * DATA_W +: DATA_W];
        just     = 16'(sample) << (16 - DATA_W);
        ch_word  = {4'b0000, CMD, nxt_ch, just, 4'b0000};
        ch_bit   = N_CH'(1) << nxt_ch;
        k_nx     = state == CFG_GAP ? k + 3'd1 : k;
        cfg_word = i_cfg_words[int'(k_nx) * 32 +: 32];
    end

    always_ff @(posedge clk100mhz)
        state <= rst ? IDLE : state_nx;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:       if (i_enable) state_nx = CFG_SEND;
            CFG_SEND:   if (send_end) state_nx = CFG_GAP;
            CFG_GAP:    if (gap_end) state_nx = k < 3'(N_CFG - 1) ? CFG_SEND : WAIT_FRAME;
            WAIT_FRAME: if (pend && rem != '0) state_nx = CH_SEND;
            CH_SEND:    if (send_end) state_nx = CH_GAP;
            CH_GAP:     if (gap_end) state_nx = rem != '0 ? CH_SEND : (LDAC_EN ? LDAC_PULSE : WAIT_FRAME);
            LDAC_PULSE: if (ldac_end) state_nx = WAIT_FRAME;
            default:    state_nx = IDLE;
        endcase
    end

    always_comb begin
        o_cs          = !sending;
        o_sck         = !(sending && half >= 7'd2 && !half[0]);
        o_sdo         = sh[31];
        o_nldac       = state != LDAC_PULSE;
        o_frame_ready = state == WAIT_FRAME && !pend;
        o_busy        = state != IDLE && state != WAIT_FRAME;
        o_cfg_done    = cfg_done;
    end

    always_ff @(posedge clk100mhz) begin
        if (rst) begin
            tick     <= '0;
            half     <= '0;
            k        <= '0;
            sh       <= '0;
            pend     <= 1'b0;
            rem      <= '0;
            data_q   <= '0;
            cfg_done <= 1'b0;
        end else begin
            if (state_nx != state) begin
                tick <= '0;
                half <= '0;
            end else if (sending && half_end) begin
                tick <= '0;
                half <= half + 1'b1;
            end else begin
                tick <= tick + 1'b1;
            end
            // The pend cycle after an accept selects the first channel, giving the 2-cycle accept-to-CS latency.
            if (o_frame_ready && i_frame_valid) begin
                pend   <= 1'b1;
                data_q <= i_data;
                rem    <= i_ch_mask;
            end else begin
                pend <= 1'b0;
            end
            if (state_nx == CFG_SEND && state != CFG_SEND) begin
                sh <= cfg_word;
                k  <= k_nx;
            end else if (state_nx == CH_SEND && state != CH_SEND) begin
                sh  <= ch_word;
                rem <= rem & ~ch_bit;
            end else if (sending && half_end && half >= 7'd2 && !half[0]) begin
                // Advance on the cycle SCK returns high so data is stable across every falling edge.
                sh <= sh << 1;
            end
            if (state == CFG_GAP && state_nx == WAIT_FRAME) cfg_done <= 1'b1;
        end
    end
endmodule

// File: tb/tb_dacx_multich_driver.sv
// tb_dacx_multich_driver: randomized self-checking bench for dacx_multich_driver against a word/timing model
module tb_dacx_multich_driver;
    localparam int N_CH = 4, DW = 16, DW2 = 12, DIV = 2, NCFG = 6, GAP = 32;
    localparam int LOW  = 66 * DIV;
    localparam int SLOT = LOW + GAP;
`ifdef DACX_LDAC_SYNC_EN
    localparam logic [3:0] CMD = 4'b0000;
    localparam int LDAC_LEN = 8;
`else
    localparam logic [3:0] CMD = 4'b0011;
    localparam int LDAC_LEN = 0;
`endif

    logic clk100mhz = 1'b0, rst = 1'b1, i_enable = 1'b0;
    logic [32*NCFG-1:0] i_cfg_words = '0;
    logic [N_CH*DW-1:0] i_data = '0;
    logic [N_CH-1:0]    i_ch_mask = '0;
    logic               i_frame_valid = 1'b0;
    logic o_frame_ready, o_cfg_done, o_busy, o_sdo, o_sck, o_cs, o_nldac;
    logic [N_CH*DW2-1:0] d2 = '0;
    logic [N_CH-1:0]     m2 = '0;
    logic                v2 = 1'b0;
    logic ready2, done2, busy2, sdo2, sck2, cs2, nldac2;

    int checks = 0, errors = 0;
    logic [31:0] cfg [NCFG];
    logic [31:0] words[$], words2[$];
    int lens[$], gaps[$];
    int partial = 0, sck_bad = 0;

    always #5 clk100mhz = ~clk100mhz;

    dacx_multich_driver #(.N_CH(N_CH), .DATA_W(DW), .SCK_DIV(DIV), .N_CFG(NCFG), .CS_GAP(GAP)) dut (
        .clk100mhz(clk100mhz), .rst(rst), .i_enable(i_enable), .i_cfg_words(i_cfg_words),
        .i_data(i_data), .i_ch_mask(i_ch_mask), .i_frame_valid(i_frame_valid),
        .o_frame_ready(o_frame_ready), .o_cfg_done(o_cfg_done), .o_busy(o_busy),
        .o_sdo(o_sdo), .o_sck(o_sck), .o_cs(o_cs), .o_nldac(o_nldac));

    dacx_multich_driver #(.N_CH(N_CH), .DATA_W(DW2), .SCK_DIV(DIV), .N_CFG(NCFG), .CS_GAP(GAP)) dut12 (
        .clk100mhz(clk100mhz), .rst(rst), .i_enable(i_enable), .i_cfg_words(i_cfg_words),
        .i_data(d2), .i_ch_mask(m2), .i_frame_valid(v2),
        .o_frame_ready(ready2), .o_cfg_done(done2), .o_busy(busy2),
        .o_sdo(sdo2), .o_sck(sck2), .o_cs(cs2), .o_nldac(nldac2));

    // Expected DAC word: command nibble, channel address, left-justified sample.
    function automatic logic [31:0] ch_word(input int c, input logic [15:0] s, input int w);
        return (32'(CMD) << 24) | (32'(c) << 20) | (32'(s) << (20 - w));
    endfunction

    // SPI receiver as the DAC sees it: shift SDO on each falling SCK while CS is low.
    logic prev_cs = 1'b1, prev_sck = 1'b1, have_prev = 1'b0;
    logic [31:0] sr = '0;
    int nb = 0, low_len = 0, high_len = 0;
    always @(negedge clk100mhz) begin
        if (o_cs && o_sck !== 1'b1) sck_bad++;
        if (!o_cs && prev_sck && !o_sck) begin
            sr = {sr[30:0], o_sdo};
            nb++;
        end
        if (!o_cs) low_len++; else high_len++;
        if (!o_cs && prev_cs && have_prev) gaps.push_back(high_len);
        if (o_cs && !prev_cs) begin
            if (nb == 32) begin
                words.push_back(sr);
                lens.push_back(low_len);
            end else partial++;
            nb = 0;
            low_len = 0;
            high_len = 1;
            have_prev = 1'b1;
        end
        if (rst) have_prev = 1'b0;
        prev_cs = o_cs;
        prev_sck = o_sck;
    end

    logic p2_cs = 1'b1, p2_sck = 1'b1;
    logic [31:0] sr2 = '0;
    int nb2 = 0;
    always @(negedge clk100mhz) begin
        if (!cs2 && p2_sck && !sck2) begin
            sr2 = {sr2[30:0], sdo2};
            nb2++;
        end
        if (cs2 && !p2_cs) begin
            if (nb2 == 32) words2.push_back(sr2);
            nb2 = 0;
        end
        p2_cs = cs2;
        p2_sck = sck2;
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk100mhz);
        checks++;
        if ({o_sck, o_cs, o_nldac, o_sdo} !== 4'b1110) begin
            errors++;
            $display("FAIL reset_pins: sck/cs/nldac/sdo=%b required 1110", {o_sck, o_cs, o_nldac, o_sdo});
        end
        checks++;
        if ({o_frame_ready, o_busy, o_cfg_done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags: ready/busy/done=%b required 000", {o_frame_ready, o_busy, o_cfg_done});
        end
        rst = 1'b0;
        repeat (5) @(negedge clk100mhz);
        checks++;
        if ({o_cs, o_frame_ready, o_busy} !== 3'b100) begin
            errors++;
            $display("FAIL idle_hold: cs/ready/busy=%b required 100", {o_cs, o_frame_ready, o_busy});
        end
    endtask

    task automatic run_config(input string name);
        int cnt = 0;
        bit ok = 0;
        words.delete();
        lens.delete();
        gaps.delete();
        i_enable = 1'b1;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk100mhz);
            cnt++;
            if (cnt == 10) begin
                checks++;
                if ({o_busy, o_cs} !== 2'b10) begin
                    errors++;
                    $display("FAIL %s busy_cs: busy/cs=%b required 10", name, {o_busy, o_cs});
                end
            end
            if (o_frame_ready) ok = 1;
        end
        i_enable = 1'b0;
        checks++;
        if (!ok || cnt != 1 + NCFG * SLOT) begin
            errors++;
            $display("FAIL %s time: ready after %0d cycles (seen=%0d) required %0d", name, cnt, ok, 1 + NCFG * SLOT);
        end
        checks++;
        if ({o_cfg_done, o_busy} !== 2'b10) begin
            errors++;
            $display("FAIL %s done: done/busy=%b required 10", name, {o_cfg_done, o_busy});
        end
        checks++;
        if (words.size() != NCFG) begin
            errors++;
            $display("FAIL %s count: %0d words required %0d", name, words.size(), NCFG);
        end
        for (int k = 0; k < NCFG && k < words.size(); k++) begin
            checks++;
            if (words[k] !== cfg[k] || lens[k] != LOW) begin
                errors++;
                $display("FAIL %s word%0d: got %h (cs low %0d) required %h (cs low %0d)", name, k, words[k], lens[k], cfg[k], LOW);
            end
        end
    endtask

    task automatic test_config();
        cfg[0] = 32'h0800000F;
        for (int k = 1; k < NCFG; k++) cfg[k] = $urandom;
        for (int k = 0; k < NCFG; k++) i_cfg_words[k*32 +: 32] = cfg[k];
        run_config("cfg");
        checks++;
        if (gaps.size() != NCFG - 1) begin
            errors++;
            $display("FAIL cfg gaps: %0d gaps required %0d", gaps.size(), NCFG - 1);
        end
        for (int k = 0; k < gaps.size(); k++) begin
            checks++;
            if (gaps[k] != GAP) begin
                errors++;
                $display("FAIL cfg gap%0d: %0d cycles required %0d", k, gaps[k], GAP);
            end
        end
    endtask

    task automatic run_frame(input string name, input logic [N_CH*DW-1:0] d, input logic [N_CH-1:0] m);
        logic [31:0] want[$];
        int base = words.size();
        int n_on = $countones(m);
        int cnt = 0, t_cs = -1, nl = 0, first_nl = -1;
        int want_rdy, want_cs, want_nl, want_first;
        bit ok = 0;
        for (int c = 0; c < N_CH; c++)
            if (m[c]) want.push_back(ch_word(c, 16'(d[c*DW +: DW]), DW));
        want_rdy   = n_on == 0 ? 2 : 2 + n_on * SLOT + LDAC_LEN;
        want_cs    = n_on == 0 ? -1 : 2;
        want_nl    = n_on == 0 ? 0 : LDAC_LEN;
        want_first = (n_on == 0 || LDAC_LEN == 0) ? -1 : 2 + n_on * SLOT;
        for (int i = 0; i < 200 && o_frame_ready !== 1'b1; i++) @(negedge clk100mhz);
        checks++;
        if (o_frame_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s ready_wait: ready=%b required 1", name, o_frame_ready);
        end
        i_data = d;
        i_ch_mask = m;
        i_frame_valid = 1'b1;
        for (int i = 0; i < 5000 && !ok; i++) begin
            @(negedge clk100mhz);
            cnt++;
            if (cnt == 1) begin
                i_frame_valid = 1'b0;
                i_data = {$urandom, $urandom};
                i_ch_mask = 4'($urandom);
                checks++;
                if (o_frame_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL %s ready_drop: ready=%b required 0", name, o_frame_ready);
                end
            end
            if (!o_cs && t_cs < 0) t_cs = cnt;
            if (!o_nldac) begin
                nl++;
                if (first_nl < 0) first_nl = cnt;
            end
            if (o_frame_ready) ok = 1;
        end
        checks++;
        if (!ok || cnt != want_rdy || t_cs != want_cs) begin
            errors++;
            $display("FAIL %s timing: ready at %0d cs fall at %0d required %0d and %0d", name, cnt, t_cs, want_rdy, want_cs);
        end
        checks++;
        if (nl != want_nl || first_nl != want_first) begin
            errors++;
            $display("FAIL %s ldac: low %0d cycles from %0d required %0d from %0d", name, nl, first_nl, want_nl, want_first);
        end
        checks++;
        if (words.size() - base != want.size()) begin
            errors++;
            $display("FAIL %s count: %0d words required %0d", name, words.size() - base, want.size());
        end
        for (int k = 0; k < want.size() && base + k < words.size(); k++) begin
            checks++;
            if (words[base+k] !== want[k] || lens[base+k] != LOW) begin
                errors++;
                $display("FAIL %s word%0d: got %h (cs low %0d) required %h (cs low %0d)", name, k, words[base+k], lens[base+k], want[k], LOW);
            end
        end
    endtask

    task automatic test_full_frame();
        run_frame("full", {16'hFFFF, 16'h0000, 16'hABCD, 16'h1234}, 4'b1111);
    endtask

    task automatic test_zero_mask();
        run_frame("zero", {$urandom, $urandom}, 4'b0000);
    endtask

    task automatic test_back_to_back();
        for (int n = 0; n < 8; n++) run_frame($sformatf("rand%0d", n), {$urandom, $urandom}, 4'($urandom));
        run_frame("sparse", {$urandom, $urandom}, 4'b1010);
        checks++;
        if ({o_cfg_done, o_busy} !== 2'b10) begin
            errors++;
            $display("FAIL enable_drop: done/busy=%b required 10", {o_cfg_done, o_busy});
        end
    endtask

    task automatic test_dw12();
        int cnt = 0;
        bit ok = 0;
        logic [31:0] want = ch_word(2, 16'h0ABC, DW2);
        words2.delete();
        d2 = 48'({$urandom, $urandom});
        d2[2*DW2 +: DW2] = 12'hABC;
        m2 = 4'b0100;
        for (int i = 0; i < 200 && ready2 !== 1'b1; i++) @(negedge clk100mhz);
        v2 = 1'b1;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk100mhz);
            cnt++;
            if (cnt == 1) begin
                v2 = 1'b0;
                m2 = 4'b1111;
                d2 = 48'({$urandom, $urandom});
            end
            if (cnt > 1 && ready2) ok = 1;
        end
        checks++;
        if (!ok || cnt != 2 + SLOT + LDAC_LEN) begin
            errors++;
            $display("FAIL dw12 timing: ready at %0d (seen=%0d) required %0d", cnt, ok, 2 + SLOT + LDAC_LEN);
        end
        checks++;
        if (words2.size() != 1 || words2[0] !== want) begin
            errors++;
            $display("FAIL dw12 word: got %0d words first %h required 1 word %h", words2.size(), words2.size() ? words2[0] : 32'h0, want);
        end
        checks++;
        if ({done2, busy2, nldac2} !== 3'b101) begin
            errors++;
            $display("FAIL dw12 flags: done/busy/nldac=%b required 101", {done2, busy2, nldac2});
        end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        int p;
        for (int i = 0; i < 200 && o_frame_ready !== 1'b1; i++) @(negedge clk100mhz);
        i_data = {$urandom, $urandom};
        i_ch_mask = 4'b1111;
        i_frame_valid = 1'b1;
        @(negedge clk100mhz);
        i_frame_valid = 1'b0;
        @(negedge clk100mhz);
        repeat (SLOT + 34 * DIV) @(negedge clk100mhz);
        checks++;
        if ({o_cs, o_sck} !== 2'b00) begin
            errors++;
            $display("FAIL mid_frame: cs/sck=%b required 00", {o_cs, o_sck});
        end
        p = partial;
        rst = 1'b1;
        @(negedge clk100mhz);
        checks++;
        if ({o_cs, o_sck, o_cfg_done, o_nldac, o_sdo} !== 5'b11010) begin
            errors++;
            $display("FAIL rst_mid: cs/sck/done/nldac/sdo=%b required 11010", {o_cs, o_sck, o_cfg_done, o_nldac, o_sdo});
        end
        checks++;
        if ({o_frame_ready, o_busy} !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_flags: ready/busy=%b required 00", {o_frame_ready, o_busy});
        end
        rst = 1'b0;
        repeat (60) begin
            @(negedge clk100mhz);
            if (o_sck !== 1'b1 || o_cs !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0 || partial != p + 1) begin
            errors++;
            $display("FAIL rst_idle: %0d active cycles, %0d partial words, required 0 and %0d", bad, partial, p + 1);
        end
        run_config("recfg");
    endtask

    task automatic test_sck_idle();
        checks++;
        if (sck_bad != 0) begin
            errors++;
            $display("FAIL sck_idle: %0d cycles with SCK low while CS high, required 0", sck_bad);
        end
    endtask

    initial begin
        test_reset();
        test_config();
        test_full_frame();
        test_zero_mask();
        test_back_to_back();
        test_dw12();
        test_reset_mid();
        test_sck_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
